// File: rtl/sensor_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_sched_pkg
//  Description : Shared types and helpers for the sensor round-robin scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package sensor_sched_pkg;

    // Scheduler FSM states: waiting for a ready buffer, or presenting a word.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int ch_width(input int n);
        if ($clog2(n) < 1)
            return 1;
        else
            return $clog2(n);
    endfunction

endpackage : sensor_sched_pkg
`default_nettype wire

// File: rtl/sensor_rr_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational first-set search over req, starting at ptr and
//                wrapping past the top channel back to channel 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_valid
);

    localparam logic [CH_W:0] c_num_ch = (CH_W+1)'(NUM_CH);

    logic [2*NUM_CH-1:0] w_req_dbl;
    logic [NUM_CH-1:0]   w_req_rot;
    logic [CH_W:0]       w_sum;

    // Rotate the request vector so the pointer channel lands at bit 0.
    assign w_req_dbl = {req, req};
    assign w_req_rot = NUM_CH'(w_req_dbl >> ptr);

    // Lowest set bit of the rotated vector wins; map it back to a channel.
    always_comb begin
        gnt_valid = |req;
        w_sum     = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_req_rot[i])
                w_sum = {1'b0, ptr} + (CH_W+1)'(i);
        end
        if (w_sum >= c_num_ch)
            w_sum = w_sum - c_num_ch;
        gnt_idx = w_sum[CH_W-1:0];
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/sensor_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_rr_scheduler
//  Description : Round-robin scheduler sharing one downstream engine between
//                NUM_CH sensor buffers, with accept timeout and drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module sensor_rr_scheduler
    import sensor_sched_pkg::*;
#(
    parameter int  NUM_CH     = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  TIMEOUT    = 255,
    parameter int  CNT_W      = 16,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
    input  logic [NUM_CH-1:0]            ch_ready,
    output logic [NUM_CH-1:0]            ch_processed,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_valid,
    input  logic                         out_accept,
    output logic                         err_timeout,
    output logic [CNT_W-1:0]             drop_count,
    output logic                         busy
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int              WAIT_W      = ch_width(TIMEOUT);
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(TIMEOUT - 1);
    localparam logic [CH_W-1:0] c_ch_last   = CH_W'(NUM_CH - 1);

    state_t                r_state, w_nxt_state;
    logic [CH_W-1:0]       r_ptr, w_nxt_ptr;
    logic [WAIT_W-1:0]     r_wait, w_nxt_wait;
    logic [NUM_CH-1:0]     r_proc, w_nxt_proc;
    logic [DATA_WIDTH-1:0] r_data, w_nxt_data;
    logic [CH_W-1:0]       r_ch, w_nxt_ch;
    logic                  r_valid, w_nxt_valid;
    logic                  r_err, w_nxt_err;
    logic [CNT_W-1:0]      r_drop, w_nxt_drop;
    logic                  r_busy, w_nxt_busy;

    logic [CH_W-1:0]       w_gnt_idx;
    logic                  w_gnt_valid;
    logic [DATA_WIDTH-1:0] w_words [NUM_CH];

    // Split the concatenated buffer bus into one word per channel.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_words[g] = ch_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .req       (ch_ready),
        .ptr       (r_ptr),
        .gnt_idx   (w_gnt_idx),
        .gnt_valid (w_gnt_valid)
    );

    // Next-state and next-output decode; everything holds unless changed.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ptr   = r_ptr;
        w_nxt_wait  = r_wait;
        w_nxt_proc  = '0;
        w_nxt_data  = r_data;
        w_nxt_ch    = r_ch;
        w_nxt_valid = r_valid;
        w_nxt_err   = 1'b0;
        w_nxt_drop  = r_drop;
        case (r_state)
            IDLE: begin
                if (enable && w_gnt_valid) begin
                    w_nxt_data  = w_words[w_gnt_idx];
                    w_nxt_ch    = w_gnt_idx;
                    w_nxt_valid = 1'b1;
                    w_nxt_proc  = NUM_CH'(1) << w_gnt_idx;
                    w_nxt_ptr   = (w_gnt_idx == c_ch_last) ? '0 : w_gnt_idx + 1'b1;
                    w_nxt_wait  = '0;
                    w_nxt_state = SEND;
                end
            end
            SEND: begin
                // Accept takes precedence over a coincident timeout.
                if (r_valid && out_accept) begin
                    w_nxt_valid = 1'b0;
                    w_nxt_state = IDLE;
                end else if (r_wait == c_wait_last) begin
                    w_nxt_valid = 1'b0;
                    w_nxt_err   = 1'b1;
                    if (r_drop != '1)
                        w_nxt_drop = r_drop + 1'b1;
                    w_nxt_state = IDLE;
                end else begin
                    w_nxt_wait = r_wait + 1'b1;
                end
            end
            default: begin
                w_nxt_valid = 1'b0;
                w_nxt_state = IDLE;
            end
        endcase
        w_nxt_busy = (w_nxt_state != IDLE);
    end

    // State and output registers; reset abandons any word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_wait  <= '0;
            r_proc  <= '0;
            r_data  <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_drop  <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_ptr   <= w_nxt_ptr;
            r_wait  <= w_nxt_wait;
            r_proc  <= w_nxt_proc;
            r_data  <= w_nxt_data;
            r_ch    <= w_nxt_ch;
            r_valid <= w_nxt_valid;
            r_err   <= w_nxt_err;
            r_drop  <= w_nxt_drop;
            r_busy  <= w_nxt_busy;
        end
    end

    assign ch_processed = r_proc;
    assign out_data     = r_data;
    assign out_ch       = r_ch;
    assign out_valid    = r_valid;
    assign err_timeout  = r_err;
    assign drop_count   = r_drop;
    assign busy         = r_busy;

endmodule : sensor_rr_scheduler
`default_nettype wire

// File: tb/tb_sensor_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sensor_rr_scheduler
//  Description : Directed self-checking bench for sensor_rr_scheduler
//                (NUM_CH=4, DATA_WIDTH=8, TIMEOUT=3, CNT_W=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_rr_scheduler;

    localparam int NUM_CH     = 4;
    localparam int DATA_WIDTH = 8;
    localparam int TIMEOUT    = 3;
    localparam int CNT_W      = 2;
    localparam int CH_W       = 2;

    logic                         clk;
    logic                         reset;
    logic                         enable;
    logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
    logic [NUM_CH-1:0]            ch_ready;
    logic [NUM_CH-1:0]            ch_processed;
    logic [DATA_WIDTH-1:0]        out_data;
    logic [CH_W-1:0]              out_ch;
    logic                         out_valid;
    logic                         out_accept;
    logic                         err_timeout;
    logic [CNT_W-1:0]             drop_count;
    logic                         busy;

    int n_checks = 0;
    int n_errors = 0;

    sensor_rr_scheduler #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT    (TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .ch_data      (ch_data),
        .ch_ready     (ch_ready),
        .ch_processed (ch_processed),
        .out_data     (out_data),
        .out_ch       (out_ch),
        .out_valid    (out_valid),
        .out_accept   (out_accept),
        .err_timeout  (err_timeout),
        .drop_count   (drop_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare the full output set; word/channel only matter while valid.
    task automatic exp_out(input string tag, input logic v, input logic [CH_W-1:0] ch,
                           input logic [7:0] d, input logic [3:0] p, input logic e,
                           input logic [CNT_W-1:0] dc, input logic b);
        check_val({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) begin
            check_val({tag, ".ch"}, 32'(out_ch), 32'(ch));
            check_val({tag, ".data"}, 32'(out_data), 32'(d));
        end
        check_val({tag, ".proc"}, 32'(ch_processed), 32'(p));
        check_val({tag, ".err"}, 32'(err_timeout), 32'(e));
        check_val({tag, ".drop"}, 32'(drop_count), 32'(dc));
        check_val({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        reset      = 1'b0;
        enable     = 1'b1;
        ch_ready   = 4'b0001;
        ch_data    = 32'h4433_22A5;
        out_accept = 1'b1;
        #12;
        exp_out("rst", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0);
        check_val("rst.data0", 32'(out_data), 32'h0);
        check_val("rst.ch0", 32'(out_ch), 32'h0);

        // 1: first grant one cycle after release
        reset = 1'b1;
        step();
        exp_out("t1.grant", 1'b1, 2'd0, 8'hA5, 4'b0001, 1'b0, 2'd0, 1'b1);
        ch_ready = 4'b0000;
        step();
        exp_out("t1.done", 1'b0, 2'd0, 8'hA5, 4'b0000, 1'b0, 2'd0, 1'b0);

        // 2: strict rotation with all channels ready
        ch_data = 32'h4433_2211;
        do_reset();
        ch_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [7:0] d_exp;
            d_exp = 8'(8'h11 * ((k % 4) + 1));
            step();
            exp_out($sformatf("t2.g%0d", k), 1'b1, 2'(k % 4), d_exp,
                    4'(4'b0001 << (k % 4)), 1'b0, 2'd0, 1'b1);
            if (k == 4)
                ch_ready = 4'b0000;
            step();
            exp_out($sformatf("t2.o%0d", k), 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0);
        end

        // 3: pointer skips to the next ready channel and wraps
        do_reset();
        ch_ready = 4'b0010;
        step();
        exp_out("t3.a", 1'b1, 2'd1, 8'h22, 4'b0010, 1'b0, 2'd0, 1'b1);
        ch_ready = 4'b0000;
        step();
        ch_ready = 4'b0010;
        step();
        exp_out("t3.b", 1'b1, 2'd1, 8'h22, 4'b0010, 1'b0, 2'd0, 1'b1);
        ch_ready = 4'b0000;
        step();
        ch_ready = 4'b1111;
        step();
        exp_out("t3.c", 1'b1, 2'd2, 8'h33, 4'b0100, 1'b0, 2'd0, 1'b1);
        step();
        step();
        exp_out("t3.d", 1'b1, 2'd3, 8'h44, 4'b1000, 1'b0, 2'd0, 1'b1);
        step();
        step();
        exp_out("t3.e", 1'b1, 2'd0, 8'h11, 4'b0001, 1'b0, 2'd0, 1'b1);
        ch_ready = 4'b0000;
        step();

        // 4: timeout drop with accept held low
        do_reset();
        out_accept = 1'b0;
        ch_ready   = 4'b0001;
        step();
        exp_out("t4.w0", 1'b1, 2'd0, 8'h11, 4'b0001, 1'b0, 2'd0, 1'b1);
        ch_ready = 4'b0000;
        step();
        exp_out("t4.w1", 1'b1, 2'd0, 8'h11, 4'b0000, 1'b0, 2'd0, 1'b1);
        step();
        exp_out("t4.w2", 1'b1, 2'd0, 8'h11, 4'b0000, 1'b0, 2'd0, 1'b1);
        step();
        exp_out("t4.drop", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b1, 2'd1, 1'b0);
        step();
        exp_out("t4.after", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 2'd1, 1'b0);

        // 5: accept on the last wait cycle wins over the timeout
        ch_ready = 4'b0001;
        step();
        exp_out("t5.w0", 1'b1, 2'd0, 8'h11, 4'b0001, 1'b0, 2'd1, 1'b1);
        ch_ready = 4'b0000;
        step();
        step();
        exp_out("t5.w2", 1'b1, 2'd0, 8'h11, 4'b0000, 1'b0, 2'd1, 1'b1);
        out_accept = 1'b1;
        step();
        exp_out("t5.acc", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 2'd1, 1'b0);
        out_accept = 1'b0;

        // 4b: drop counter saturates at all-ones
        for (int d = 2; d <= 4; d++) begin
            ch_ready = 4'b0001;
            step();
            ch_ready = 4'b0000;
            step();
            step();
            step();
            check_val($sformatf("t4s.err%0d", d), 32'(err_timeout), 32'h1);
            check_val($sformatf("t4s.cnt%0d", d), 32'(drop_count), 32'((d > 3) ? 3 : d));
            step();
        end

        // 6a: enable low lets the current word finish but blocks new grants
        do_reset();
        ch_ready = 4'b1111;
        step();
        exp_out("t6a.grant", 1'b1, 2'd0, 8'h11, 4'b0001, 1'b0, 2'd0, 1'b1);
        enable     = 1'b0;
        out_accept = 1'b1;
        step();
        exp_out("t6a.done", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            exp_out($sformatf("t6a.hold%0d", k), 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0);
        end

        // 6b: asynchronous reset mid-SEND
        enable     = 1'b1;
        out_accept = 1'b0;
        step();
        exp_out("t6b.grant", 1'b1, 2'd1, 8'h22, 4'b0010, 1'b0, 2'd0, 1'b1);
        #2 reset = 1'b0;
        #1;
        exp_out("t6b.rst", 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0);
        check_val("t6b.data0", 32'(out_data), 32'h0);
        check_val("t6b.ch0", 32'(out_ch), 32'h0);
        out_accept = 1'b1;
        #1 reset = 1'b1;
        step();
        exp_out("t6b.restart", 1'b1, 2'd0, 8'h11, 4'b0001, 1'b0, 2'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_sensor_rr_scheduler
`default_nettype wire

// File: doc/sensor_rr_scheduler.md
Name: sensor_rr_scheduler

Overview:
Round-robin scheduler that shares one downstream processing engine between NUM_CH serial-to-parallel sensor input buffers.
- Watches each buffer's word-ready flag and grants one channel at a time.
- Returns the one-cycle processed acknowledge to the granted buffer.
- Forwards the captured word and its channel id over a valid/accept handshake.
- Drops a word with an error pulse if downstream stalls past a timeout.

Parameters:
- NUM_CH, 4, number of input buffers served (>=2).
- DATA_WIDTH, 8, word width of each buffer.
- TIMEOUT, 255, max cycles out_valid may wait for out_accept before drop (>=1).
- CNT_W, 16, width of the drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  permits new grants when high.
- ch_data  in  NUM_CH*DATA_WIDTH  concatenated buffer words; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ch_ready  in  NUM_CH  per-channel word-ready flags.
- ch_processed  out  NUM_CH  one-hot, one-cycle acknowledge to the granted buffer.
- out_data  out  DATA_WIDTH  forwarded word.
- out_ch  out  CH_W  channel id of out_data; CH_W = max(1, clog2(NUM_CH)).
- out_valid  out  1  out_data/out_ch valid.
- out_accept  in  1  downstream takes the word when out_valid && out_accept.
- err_timeout  out  1  one-cycle pulse when a word is dropped.
- drop_count  out  CNT_W  saturating count of dropped words.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- One clock domain. Async active-low reset clears every register:
  - outputs: ch_processed=0, out_data=0, out_ch=0, out_valid=0, err_timeout=0, drop_count=0, busy=0;
  - internal: state=IDLE, priority pointer=0, wait counter=0.
- Reset mid-transfer abandons the word. No ack is sent afterwards.
- All outputs are registered.
- States:
  - IDLE:
    - If enable && |ch_ready: pick the first ready channel g, searching upward from the pointer with wrap (ptr, ptr+1, ..., NUM_CH-1, 0, ...).
    - Next cycle: out_data=ch_data[g], out_ch=g, out_valid=1, ch_processed[g]=1, pointer=(g+1) mod NUM_CH, wait=0, go to SEND.
    - Otherwise stay in IDLE.
  - SEND:
    - ch_processed is high only in the first SEND cycle.
    - Each cycle with out_valid && out_accept: out_valid=0 next cycle, go to IDLE.
    - Else if wait == TIMEOUT-1: out_valid=0, err_timeout=1 for one cycle, drop_count += 1 (saturating at all-ones), go to IDLE.
    - Else wait += 1. out_data and out_ch stay stable.
- Latency: ch_ready sampled high in cycle N gives out_valid and ch_processed high in cycle N+1.
- Throughput: best case one word per 2 cycles per channel set (IDLE cycle + one SEND cycle).
- The buffer clears its ready flag the cycle after ch_processed. The return to IDLE is never earlier than that, so a granted word is never double-granted.
- enable low: no new grant from IDLE. A word already in SEND completes normally.
- Simultaneous ready on all channels: strict rotation 0,1,2,3,0,... from reset.
- If the pointer channel is not ready, the next ready channel upward wins and the pointer moves past it.
- out_accept while out_valid is low is ignored.
- A timeout that coincides with out_accept in the same cycle counts as accepted: no drop, no error pulse.
- Only one ch_processed bit is ever high, and it is never high in IDLE.

Decomposition:
- Package sensor_sched_pkg holds:
  - state enum (IDLE, SEND);
  - function ch_width(n) returning max(1, clog2(n)).
- Sub-module rr_pick: purely combinational first-set search from pointer with wrap.
  - Inputs: req[NUM_CH], ptr.
  - Outputs: gnt_idx, gnt_valid.
- FSM, timeout counter and output registers stay in sensor_rr_scheduler.

Test Plan:
1. Reset with ch_ready=4'b0001, ch_data[7:0]=8'hA5, out_accept=1, enable=1. Release reset. Required: out_valid=1, out_data=A5, out_ch=0, ch_processed=0001 one cycle later; out_valid=0 the cycle after.
2. All four channels ready continuously, out_accept=1. Required: out_ch sequence 0,1,2,3,0 with out_valid every other cycle; exactly one ch_processed bit per grant.
3. Pointer at 2, only channel 1 ready. Required: grant ch1, then pointer=2. With all ready next, ch2 is granted before ch0.
4. TIMEOUT=3, out_accept held 0. Required: out_valid high exactly 3 cycles, err_timeout pulse on the following cycle, drop_count 0->1, busy drops. Repeat with drop_count preset near saturation: it holds at all-ones.
5. out_accept asserted on the same cycle the wait counter reaches TIMEOUT-1. Required: word accepted, no err_timeout, drop_count unchanged.
6. Two further checks:
   - enable deasserted during SEND: current word completes, no further grants while ch_ready=1111.
   - reset pulsed mid-SEND: all outputs return to 0 immediately and the pointer restarts at 0.
